// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: NOP encoding, fetch FSM states, default reset PC,
// and the word-alignment helper applied to redirect targets.
package if_stage_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FS_BOOT   = 2'd0,
      FS_RUN    = 2'd1,
      FS_HALTED = 2'd2
   } fetch_state_e;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one-cycle capture on load, holds otherwise, flush wins over load.
// No internal backpressure; the owner gates load/flush against its own stall logic.
module if_id_reg
   import if_stage_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        load_i,
   input  logic        flush_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] pc_plus4_i,
   input  logic [31:0] instr_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] instr_o
);

   logic        valid_q;
   logic [31:0] pc_q;
   logic [31:0] pc_plus4_q;
   logic [31:0] instr_q;

   // A flush only kills validity and the instruction word; the PC fields keep their last value.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_q    <= 1'b0;
         pc_q       <= 32'h0;
         pc_plus4_q <= 32'h0;
         instr_q    <= NOP_INSTR;
      end else if (flush_i) begin
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
      end else if (load_i) begin
         valid_q    <= 1'b1;
         pc_q       <= pc_i;
         pc_plus4_q <= pc_plus4_i;
         instr_q    <= instr_i;
      end
   end

   assign valid_o    = valid_q;
   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_plus4_q;
   assign instr_o    = instr_q;

endmodule

// File: rtl/if_stage.sv
// RV32I fetch stage: PC, BOOT/RUN/HALTED control, IF/ID capture; one instr/cycle, redirect costs one bubble.
// Stall freezes PC, IF/ID and the fetch counter in the same edge; redirect > halt > stall > fetch.
module if_stage #(
   parameter logic [31:0] RESET_PC = if_stage_pkg::DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] if_id_instr,
   output logic        misaligned,
   output logic        halted,
   output logic [31:0] fetch_count
);

   import if_stage_pkg::*;

   localparam logic [1:0] ST_BOOT   = FS_BOOT;
   localparam logic [1:0] ST_RUN    = FS_RUN;
   localparam logic [1:0] ST_HALTED = FS_HALTED;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic        misaligned_q, misaligned_d;
   logic        halted_q;
   logic        load;
   logic        flush;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_count_d = fetch_count_q;
      misaligned_d  = 1'b0;
      load          = 1'b0;
      flush         = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (redirect_valid) begin
               pc_d         = align_word(redirect_pc);
               flush        = 1'b1;
               misaligned_d = |redirect_pc[1:0];
            end else if (halt_req) begin
               flush   = 1'b1;
               state_d = ST_HALTED;
            end else if (!stall) begin
               load          = 1'b1;
               pc_d          = pc_plus4;
               fetch_count_d = fetch_count_q + 32'd1;
            end
         end
         ST_HALTED: begin
            // Only a redirect restarts fetch; stall and halt_req are ignored here.
            flush = 1'b1;
            if (redirect_valid) begin
               pc_d         = align_word(redirect_pc);
               misaligned_d = |redirect_pc[1:0];
               state_d      = ST_RUN;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         fetch_count_q <= 32'h0;
         misaligned_q  <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_count_q <= fetch_count_d;
         misaligned_q  <= misaligned_d;
         halted_q      <= (state_d == ST_HALTED);
      end
   end

   if_id_reg u_if_id_reg (
      .clk_i      (clk),
      .reset_i    (reset),
      .load_i     (load),
      .flush_i    (flush),
      .pc_i       (pc_q),
      .pc_plus4_i (pc_plus4),
      .instr_i    (imem_instr),
      .valid_o    (if_id_valid),
      .pc_o       (if_id_pc),
      .pc_plus4_o (if_id_pc_plus4),
      .instr_o    (if_id_instr)
   );

   assign imem_pc     = pc_q;
   assign misaligned  = misaligned_q;
   assign halted      = halted_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: two instances (reset PC 0 and 0xFFFF_FFFC) share stimulus and a
// 4 KB memory; a priority-rule model is compared every cycle, plus directed literal checks.
module tb_if_stage;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] RPC0  = 32'h0000_0000;
   localparam logic [31:0] RPC1  = 32'hFFFF_FFFC;
   localparam logic [31:0] W_A   = 32'h0010_0093;
   localparam logic [31:0] W_B   = 32'h0020_0113;
   localparam logic [31:0] W_C   = 32'h0030_0193;
   localparam logic [31:0] W_D   = 32'h0040_0213;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;

   logic [31:0] imem_pc        [2];
   logic [31:0] imem_instr     [2];
   logic        if_id_valid    [2];
   logic [31:0] if_id_pc       [2];
   logic [31:0] if_id_pc_plus4 [2];
   logic [31:0] if_id_instr    [2];
   logic        misaligned     [2];
   logic        halted         [2];
   logic [31:0] fetch_count    [2];

   logic [31:0] mem [1024];

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   assign imem_instr[0] = mem[imem_pc[0][11:2]];
   assign imem_instr[1] = mem[imem_pc[1][11:2]];

   if_stage #(.RESET_PC(RPC0)) dut0 (
      .clk(clk), .reset(reset), .imem_pc(imem_pc[0]), .imem_instr(imem_instr[0]),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .if_id_valid(if_id_valid[0]), .if_id_pc(if_id_pc[0]),
      .if_id_pc_plus4(if_id_pc_plus4[0]), .if_id_instr(if_id_instr[0]),
      .misaligned(misaligned[0]), .halted(halted[0]), .fetch_count(fetch_count[0])
   );

   if_stage #(.RESET_PC(RPC1)) dut1 (
      .clk(clk), .reset(reset), .imem_pc(imem_pc[1]), .imem_instr(imem_instr[1]),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .if_id_valid(if_id_valid[1]), .if_id_pc(if_id_pc[1]),
      .if_id_pc_plus4(if_id_pc_plus4[1]), .if_id_instr(if_id_instr[1]),
      .misaligned(misaligned[1]), .halted(halted[1]), .fetch_count(fetch_count[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what the fetch unit must present, derived from the priority rules.
   logic [31:0] m_pc [2], m_ipc [2], m_ipc4 [2], m_instr [2], m_cnt [2];
   bit          m_valid [2], m_mis [2], m_halted [2], m_boot [2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = (k == 0) ? RPC0 : RPC1;
         m_ipc[k] = 0; m_ipc4[k] = 0; m_instr[k] = NOP; m_cnt[k] = 0;
         m_valid[k] = 0; m_mis[k] = 0; m_halted[k] = 0; m_boot[k] = 1;
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_pc[k] = (k == 0) ? RPC0 : RPC1;
            m_ipc[k] = 0; m_ipc4[k] = 0; m_instr[k] = NOP; m_cnt[k] = 0;
            m_valid[k] = 0; m_mis[k] = 0; m_halted[k] = 0; m_boot[k] = 1;
         end else begin
            m_mis[k] = 0;
            if (m_boot[k]) begin
               m_boot[k] = 0;
            end else if (redirect_valid) begin
               m_pc[k] = redirect_pc & 32'hFFFF_FFFC;
               m_valid[k] = 0; m_instr[k] = NOP;
               m_mis[k] = (redirect_pc % 4) != 0;
               m_halted[k] = 0;
            end else if (m_halted[k]) begin
               m_valid[k] = 0; m_instr[k] = NOP;
            end else if (halt_req) begin
               m_valid[k] = 0; m_instr[k] = NOP; m_halted[k] = 1;
            end else if (!stall) begin
               m_valid[k] = 1;
               m_ipc[k] = m_pc[k];
               m_ipc4[k] = m_pc[k] + 4;
               m_instr[k] = mem[(m_pc[k] / 4) % 1024];
               m_pc[k] = m_pc[k] + 4;
               m_cnt[k] = m_cnt[k] + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d imem_pc", k), imem_pc[k], m_pc[k]);
            chk($sformatf("u%0d valid", k), {31'b0, if_id_valid[k]}, {31'b0, m_valid[k]});
            chk($sformatf("u%0d instr", k), if_id_instr[k], m_instr[k]);
            chk($sformatf("u%0d misaligned", k), {31'b0, misaligned[k]}, {31'b0, m_mis[k]});
            chk($sformatf("u%0d halted", k), {31'b0, halted[k]}, {31'b0, m_halted[k]});
            chk($sformatf("u%0d fetch_count", k), fetch_count[k], m_cnt[k]);
            if (m_valid[k]) begin
               chk($sformatf("u%0d if_id_pc", k), if_id_pc[k], m_ipc[k]);
               chk($sformatf("u%0d if_id_pc_plus4", k), if_id_pc_plus4[k], m_ipc4[k]);
            end
         end
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, " imem_pc0"}, imem_pc[0], RPC0);
      chk({tag, " imem_pc1"}, imem_pc[1], RPC1);
      chk({tag, " valid"}, {31'b0, if_id_valid[0]}, 32'd0);
      chk({tag, " if_id_pc"}, if_id_pc[0], 32'd0);
      chk({tag, " if_id_pc_plus4"}, if_id_pc_plus4[0], 32'd0);
      chk({tag, " instr"}, if_id_instr[0], NOP);
      chk({tag, " misaligned"}, {31'b0, misaligned[0]}, 32'd0);
      chk({tag, " halted"}, {31'b0, halted[0]}, 32'd0);
      chk({tag, " fetch_count"}, fetch_count[0], 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[0] = W_A; mem[1] = W_B; mem[2] = W_C; mem[3] = W_D;
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0;

      repeat (2) @(negedge clk);
      chk_reset_vals("rst");
      cmp_en = 1'b1;
      reset = 1'b0;

      @(negedge clk);
      chk("boot valid", {31'b0, if_id_valid[0]}, 32'd0);
      chk("boot imem_pc", imem_pc[0], 32'h0);
      @(negedge clk);
      chk("first instr", if_id_instr[0], W_A);
      chk("first pc", if_id_pc[0], 32'h0);
      chk("first pc4", if_id_pc_plus4[0], 32'h4);
      chk("first valid", {31'b0, if_id_valid[0]}, 32'd1);
      chk("imem_pc 4", imem_pc[0], 32'h4);
      repeat (2) @(negedge clk);
      chk("instr C", if_id_instr[0], W_C);
      chk("imem_pc C", imem_pc[0], 32'hC);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall imem_pc", imem_pc[0], 32'hC);
         chk("stall if_id_pc", if_id_pc[0], 32'h8);
         chk("stall count", fetch_count[0], 32'd3);
      end
      stall = 1'b0;
      @(negedge clk);
      chk("after stall pc", if_id_pc[0], 32'hC);
      chk("instr D", if_id_instr[0], W_D);
      chk("count 4", fetch_count[0], 32'd4);

      redirect_valid = 1'b1; redirect_pc = 32'h30; stall = 1'b1;
      @(negedge clk);
      chk("redir imem_pc", imem_pc[0], 32'h30);
      chk("redir valid", {31'b0, if_id_valid[0]}, 32'd0);
      chk("redir instr", if_id_instr[0], NOP);
      redirect_valid = 1'b0; stall = 1'b0;
      @(negedge clk);
      chk("redir tgt pc", if_id_pc[0], 32'h30);
      chk("redir tgt valid", {31'b0, if_id_valid[0]}, 32'd1);

      redirect_valid = 1'b1; redirect_pc = 32'h32;
      @(negedge clk);
      chk("misal imem_pc", imem_pc[0], 32'h30);
      chk("misal pulse", {31'b0, misaligned[0]}, 32'd1);
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("misal clear", {31'b0, misaligned[0]}, 32'd0);

      redirect_valid = 1'b1; redirect_pc = 32'h10;
      @(negedge clk);
      redirect_valid = 1'b0; halt_req = 1'b1;
      @(negedge clk);
      chk("halt halted", {31'b0, halted[0]}, 32'd1);
      chk("halt valid", {31'b0, if_id_valid[0]}, 32'd0);
      chk("halt imem_pc", imem_pc[0], 32'h10);
      halt_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         stall = (i % 2) == 0;
         halt_req = (i == 2);
         @(negedge clk);
         chk("halted imem_pc", imem_pc[0], 32'h10);
         chk("halted stays", {31'b0, halted[0]}, 32'd1);
      end
      stall = 1'b0; halt_req = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      @(negedge clk);
      chk("unhalt halted", {31'b0, halted[0]}, 32'd0);
      chk("unhalt imem_pc", imem_pc[0], 32'h0);
      chk("unhalt valid", {31'b0, if_id_valid[0]}, 32'd0);
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("unhalt instr", if_id_instr[0], W_A);
      chk("unhalt valid2", {31'b0, if_id_valid[0]}, 32'd1);

      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("midrst");
      reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("wrap if_id_pc", if_id_pc[1], 32'hFFFF_FFFC);
      chk("wrap pc4", if_id_pc_plus4[1], 32'h0);
      chk("wrap imem_pc", imem_pc[1], 32'h0);

      for (int i = 0; i < 3000; i++) begin
         reset          = ($urandom_range(0, 199) == 0);
         stall          = ($urandom_range(0, 3) == 0);
         redirect_valid = ($urandom_range(0, 11) == 0);
         halt_req       = ($urandom_range(0, 19) == 0);
         redirect_pc    = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
         @(negedge clk);
      end
      reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
